// File: rtl/valid_flag_table.sv
// valid_flag_table
//   Multi-read-port valid-bit table for hash-table buckets, one flag per bucket
//   address. The flag array has no flop reset; instead a sequential sweep writes
//   zero to every entry after reset or on clear_req, so the array can map onto
//   distributed RAM. Occupancy (count/full/empty) is tracked for the insert
//   controller.
//
// Ports
//   clk        clock, all logic on posedge
//   reset      synchronous, active-high; restarts the sweep from address 0
//   clear_req  pulse in IDLE: start a sweep-clear (ignored while sweeping)
//   busy       1 while the sweep is running or reset is high
//   wr_en      write request, accepted when wr_en & wr_ready
//   wr_adr     write address
//   wr_valid   value written (1 = occupied, 0 = freed)
//   wr_ready   ~busy
//   rd_adr     packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   flag_out   registered flag per read port (1-cycle latency)
//   count      number of entries currently set
//   full       count == DEPTH
//   empty      count == 0

module valid_flag_table #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned NUM_RD = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_adr,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_adr,
    output logic [NUM_RD-1:0]        flag_out,
    output logic [ADDR_W:0]          count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned     DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [NUM_RD-1:0] flag_q, flag_d;
    logic              mem_q [DEPTH];

    logic wr_acc;
    logic wr_old;

    assign busy     = reset | (state_q == CLEAR);
    assign wr_ready = ~busy;
    assign wr_acc   = wr_en & ~busy;
    assign wr_old   = mem_q[wr_adr];

    // Sweep / idle control
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                if (clr_ptr_q == '1) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Occupancy: only a real 0->1 or 1->0 transition moves the count, so
    // rewriting the same value can never over- or underflow it.
    always_comb begin
        count_d = count_q;
        if (state_q == IDLE && clear_req) begin
            count_d = '0;
        end else if (wr_acc) begin
            if (!wr_old && wr_valid) begin
                count_d = count_q + (ADDR_W+1)'(1);
            end else if (wr_old && !wr_valid) begin
                count_d = count_q - (ADDR_W+1)'(1);
            end
        end
    end

    // Read ports; an accepted write to the same address is forwarded when BYPASS.
    always_comb begin
        flag_d = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (state_q != IDLE) begin
                flag_d[i] = 1'b0;
            end else if (BYPASS && wr_acc && (rd_adr[i*ADDR_W +: ADDR_W] == wr_adr)) begin
                flag_d[i] = wr_valid;
            end else begin
                flag_d[i] = mem_q[rd_adr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            count_q   <= '0;
            flag_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            count_q   <= count_d;
            flag_q    <= flag_d;
        end
    end

    // Flag array: no reset, cleared by the sweep.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_ptr_q] <= 1'b0;
        end else if (wr_acc) begin
            mem_q[wr_adr] <= wr_valid;
        end
    end

    assign flag_out = flag_q;
    assign count    = count_q;
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);

endmodule

// File: tb/tb_valid_flag_table.sv
module tb_valid_flag_table;

    localparam int unsigned AW = 4;
    localparam int unsigned NR = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_req;
    logic          wr_en;
    logic [AW-1:0] wr_adr;
    logic          wr_valid;
    logic [NR*AW-1:0] rd_adr;

    logic          busy, wr_ready, full, empty;
    logic [NR-1:0] flag_out;
    logic [AW:0]   count;

    logic          busy_nb, wr_ready_nb, full_nb, empty_nb;
    logic [NR-1:0] flag_out_nb;
    logic [AW:0]   count_nb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    valid_flag_table #(.ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
        .wr_en(wr_en), .wr_adr(wr_adr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_adr(rd_adr), .flag_out(flag_out), .count(count), .full(full), .empty(empty)
    );

    valid_flag_table #(.ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy_nb),
        .wr_en(wr_en), .wr_adr(wr_adr), .wr_valid(wr_valid), .wr_ready(wr_ready_nb),
        .rd_adr(rd_adr), .flag_out(flag_out_nb), .count(count_nb), .full(full_nb), .empty(empty_nb)
    );

    // Advance one clock; outputs are then stable and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; clear_req = 1'b0; wr_en = 1'b0; wr_adr = '0; wr_valid = 1'b0; rd_adr = '0;
        step(); step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy got %b exp 1", busy); end
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL reset_empty_full got e=%b f=%b exp e=1 f=0", empty, full); end
        tests++; if (flag_out !== 2'b00) begin fails++; $display("FAIL reset_flag got %b exp 00", flag_out); end
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin step(); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL sweep_len got %0d exp 16", n); end
        tests++; if (wr_ready !== 1'b1 || busy_nb !== 1'b0) begin fails++; $display("FAIL post_sweep_ready got %b/%b exp 1/0", wr_ready, busy_nb); end
        tests++; if (count !== 5'd0 || empty !== 1'b1 || flag_out !== 2'b00) begin fails++; $display("FAIL post_sweep_state got c=%0d e=%b f=%b exp 0 1 00", count, empty, flag_out); end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_adr = 4'd5; wr_valid = 1'b1; rd_adr = '0;
        step();
        wr_en = 1'b0; rd_adr = {4'd6, 4'd5};
        step();
        tests++; if (flag_out !== 2'b01) begin fails++; $display("FAIL read_after_write got %b exp 01", flag_out); end
        tests++; if (count !== 5'd1 || empty !== 1'b0) begin fails++; $display("FAIL count_after_write got %0d e=%b exp 1 0", count, empty); end
        rd_adr = {4'd5, 4'd5};
        step();
        tests++; if (flag_out !== 2'b11) begin fails++; $display("FAIL shared_read_adr got %b exp 11", flag_out); end
    endtask

    task automatic test_collision();
        wr_en = 1'b1; wr_adr = 4'd7; wr_valid = 1'b1; rd_adr = {4'd3, 4'd7};
        step();
        tests++; if (flag_out !== 2'b01) begin fails++; $display("FAIL bypass1_collision got %b exp 01", flag_out); end
        tests++; if (flag_out_nb !== 2'b00) begin fails++; $display("FAIL bypass0_collision got %b exp 00", flag_out_nb); end
        wr_en = 1'b0;
        step();
        tests++; if (flag_out_nb !== 2'b01) begin fails++; $display("FAIL bypass0_after got %b exp 01", flag_out_nb); end
        tests++; if (count !== 5'd2 || count_nb !== 5'd2) begin fails++; $display("FAIL count_two got %0d/%0d exp 2/2", count, count_nb); end
    endtask

    task automatic test_count_rewrite();
        logic [AW:0] exp_c [5];
        logic        vals  [5];
        logic [AW-1:0] adrs [5];
        adrs[0] = 4'd7; vals[0] = 1'b0; exp_c[0] = 5'd1;
        adrs[1] = 4'd5; vals[1] = 1'b1; exp_c[1] = 5'd1;
        adrs[2] = 4'd5; vals[2] = 1'b1; exp_c[2] = 5'd1;
        adrs[3] = 4'd5; vals[3] = 1'b0; exp_c[3] = 5'd0;
        adrs[4] = 4'd5; vals[4] = 1'b0; exp_c[4] = 5'd0;
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; wr_adr = adrs[k]; wr_valid = vals[k];
            step();
            tests++; if (count !== exp_c[k]) begin fails++; $display("FAIL rewrite_count[%0d] got %0d exp %0d", k, count, exp_c[k]); end
        end
        wr_en = 1'b0;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rewrite_empty got %b exp 1", empty); end
    endtask

    task automatic test_full_and_clear();
        int n;
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_adr = AW'(a); wr_valid = 1'b1;
            step();
        end
        wr_en = 1'b0;
        tests++; if (count !== 5'd16 || full !== 1'b1 || empty !== 1'b0) begin fails++; $display("FAIL fill_all got c=%0d f=%b e=%b exp 16 1 0", count, full, empty); end
        rd_adr = {4'd9, 4'd2};
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        tests++; if (count !== 5'd0 || full !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL clear_edge got c=%0d f=%b b=%b exp 0 0 1", count, full, busy); end
        wr_en = 1'b1; wr_adr = 4'd3; wr_valid = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 4) clear_req = 1'b1;
            else clear_req = 1'b0;
            step(); n++;
        end
        clear_req = 1'b0;
        tests++; if (n != 16) begin fails++; $display("FAIL clear_sweep_len got %0d exp 16", n); end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL write_dropped_count got %0d exp 0", count); end
        tests++; if (flag_out !== 2'b00) begin fails++; $display("FAIL read_in_clear got %b exp 00", flag_out); end
        wr_en = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_adr = {AW'(15 - a), AW'(a)};
            step();
            tests++; if (flag_out !== 2'b00) begin fails++; $display("FAIL cleared_read[%0d] got %b exp 00", a, flag_out); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        wr_en = 1'b1; wr_adr = 4'd11; wr_valid = 1'b1;
        step();
        wr_en = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 8; k++) step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_sweep_busy got %b exp 1", busy); end
        reset = 1'b1;
        step();
        tests++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin fails++; $display("FAIL reset_mid_busy got b=%b r=%b exp 1 0", busy, wr_ready); end
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin step(); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL restart_sweep_len got %0d exp 16", n); end
        rd_adr = {4'd0, 4'd11};
        step();
        tests++; if (flag_out !== 2'b00 || count !== 5'd0) begin fails++; $display("FAIL after_restart got f=%b c=%0d exp 00 0", flag_out, count); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_count_rewrite();
        test_full_and_clear();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
